// File: rtl/pla_sweep_driver_if.sv
//------------------------------------------------------------------------------
// Module  : pla_sweep_driver_if
// Brief   : Control, stimulus and result bundle of the PLA sweep driver.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pla_sweep_driver_if #(
  parameter int N_IN = 16
) ();
  logic            start;
  logic            abort;
  logic            z_in;
  logic [N_IN-1:0] x_out;
  logic            busy;
  logic            done;
  logic [N_IN:0]   ones_count;
  logic [N_IN-1:0] first_one;
  logic            first_one_valid;
  logic [15:0]     signature;

  modport master (
    output start, abort, z_in,
    input  x_out, busy, done, ones_count, first_one, first_one_valid, signature
  );

  modport slave (
    input  start, abort, z_in,
    output x_out, busy, done, ones_count, first_one, first_one_valid, signature
  );
endinterface

`default_nettype wire

// File: rtl/pla_sweep_driver.sv
//------------------------------------------------------------------------------
// Module  : pla_sweep_driver
// Brief   : Exhaustive PLA input sweep with on-set count, first minterm and
//           16-bit serial response signature.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pla_sweep_driver #(
  parameter int          N_IN     = 16,
  parameter int          SETTLE   = 1,
  parameter logic [15:0] SIG_POLY = 16'h1021
) (
  input wire                clk,
  input wire                rst_n,
  pla_sweep_driver_if.slave sweep
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]      C_SETTLE = 4'(SETTLE);
  localparam logic [N_IN-1:0] C_X_LAST = '1;
  localparam logic [N_IN-1:0] C_X_ONE  = N_IN'(1);

  state_t          state_q;
  logic [N_IN-1:0] x_q;
  logic [3:0]      cnt_q;
  logic [N_IN:0]   ones_q;
  logic [N_IN-1:0] first_q;
  logic            first_vld_q;
  logic [15:0]     sig_q;
  logic            busy_q;
  logic            done_q;

  logic [15:0]     sig_d;
  logic [N_IN:0]   ones_d;

  assign sig_d  = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ sweep.z_in) ? SIG_POLY : 16'h0000);
  assign ones_d = ones_q + (N_IN+1)'(sweep.z_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      cnt_q       <= 4'd0;
      ones_q      <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      sig_q       <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sweep.start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            x_q         <= '0;
            cnt_q       <= 4'd0;
            ones_q      <= '0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
            sig_q       <= 16'h0000;
          end
        end
        S_RUN: begin
          // Abort wins over a sample due on the same edge; results stay as-is.
          if (sweep.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            x_q     <= '0;
            cnt_q   <= 4'd0;
          end else if (cnt_q != C_SETTLE) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            cnt_q  <= 4'd0;
            ones_q <= ones_d;
            sig_q  <= sig_d;
            if (sweep.z_in && !first_vld_q) begin
              first_q     <= x_q;
              first_vld_q <= 1'b1;
            end
            if (x_q == C_X_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              x_q     <= '0;
            end else begin
              x_q <= x_q + C_X_ONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sweep.x_out           = x_q;
  assign sweep.busy            = busy_q;
  assign sweep.done            = done_q;
  assign sweep.ones_count      = ones_q;
  assign sweep.first_one       = first_q;
  assign sweep.first_one_valid = first_vld_q;
  assign sweep.signature       = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_pla_sweep_driver.sv
//------------------------------------------------------------------------------
// Module  : tb_pla_sweep_driver
// Brief   : Self-checking bench for pla_sweep_driver (4-input and 10-input DUTs).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pla_sweep_driver;

  localparam int NA      = 4;
  localparam int NB      = 10;
  localparam int SB      = 3;
  localparam int SWEEP_B = (1 << NB) * (SB + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pla_sweep_driver_if #(.N_IN(NA)) ifa ();
  pla_sweep_driver_if #(.N_IN(NB)) ifb ();

  pla_sweep_driver #(.N_IN(NA), .SETTLE(0), .SIG_POLY(16'h1021)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sweep (ifa.slave)
  );

  pla_sweep_driver #(.N_IN(NB), .SETTLE(SB), .SIG_POLY(16'h1021)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sweep (ifb.slave)
  );

  // Behavioural PLAs: A is a 16-entry truth table, B a small set of functions.
  logic [15:0] tt_a;
  int          mode_b;

  always_comb ifa.z_in = tt_a[ifa.x_out];
  always_comb begin
    case (mode_b)
      0:       ifb.z_in = 1'b0;
      1:       ifb.z_in = ifb.x_out[0];
      default: ifb.z_in = 1'b1;
    endcase
  end

  typedef struct {
    logic [15:0] tt;
    int          ones;
    int          first;
    logic        fv;
  } vec_t;

  typedef struct {
    int          ones;
    int          first;
    logic        fv;
    logic [15:0] sig;
  } exp_t;

  vec_t tbl[7];
  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic z);
    return {s[14:0], 1'b0} ^ ((s[15] ^ z) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] sig_a(input logic [15:0] tt);
    logic [15:0] s;
    s = 16'h0000;
    for (int v = 0; v < 16; v++) s = sig_step(s, tt[v]);
    return s;
  endfunction

  function automatic logic zb_of(input int mode, input int v);
    logic [31:0] vv;
    vv = v;
    case (mode)
      0:       return 1'b0;
      1:       return vv[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] sig_b(input int mode, input int nvec);
    logic [15:0] s;
    s = 16'h0000;
    for (int v = 0; v < nvec; v++) s = sig_step(s, zb_of(mode, v));
    return s;
  endfunction

  // Scoreboard consumers: every done pulse must match a queued expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && ifa.done) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 32'(ifa.done), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_ones_count", 32'(ifa.ones_count), e.ones);
        chk("a_first_one", 32'(ifa.first_one), e.first);
        chk("a_first_valid", 32'(ifa.first_one_valid), 32'(e.fv));
        chk("a_signature", 32'(ifa.signature), 32'(e.sig));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && ifb.done) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 32'(ifb.done), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_ones_count", 32'(ifb.ones_count), e.ones);
        chk("b_first_one", 32'(ifb.first_one), e.first);
        chk("b_first_valid", 32'(ifb.first_one_valid), 32'(e.fv));
        chk("b_signature", 32'(ifb.signature), 32'(e.sig));
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_a_x"}, 32'(ifa.x_out), 32'd0);
    chk({tag, "_a_busy"}, 32'(ifa.busy), 32'd0);
    chk({tag, "_a_done"}, 32'(ifa.done), 32'd0);
    chk({tag, "_a_ones"}, 32'(ifa.ones_count), 32'd0);
    chk({tag, "_a_first"}, 32'(ifa.first_one), 32'd0);
    chk({tag, "_a_fv"}, 32'(ifa.first_one_valid), 32'd0);
    chk({tag, "_a_sig"}, 32'(ifa.signature), 32'd0);
  endtask

  task automatic run_a(input int idx);
    exp_t e;
    tt_a    = tbl[idx].tt;
    e.ones  = tbl[idx].ones;
    e.first = tbl[idx].first;
    e.fv    = tbl[idx].fv;
    e.sig   = sig_a(tbl[idx].tt);
    @(negedge clk);
    ifa.start = 1'b1;
    qa.push_back(e);
    @(negedge clk);
    ifa.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("a_busy", 32'(ifa.busy), 32'd1);
      chk("a_x_hold", 32'(ifa.x_out), k);
      @(negedge clk);
    end
    chk("a_end_busy", 32'(ifa.busy), 32'd0);
    chk("a_end_done", 32'(ifa.done), 32'd1);
    chk("a_end_x", 32'(ifa.x_out), 32'd0);
    @(negedge clk);
    chk("a_done_pulse", 32'(ifa.done), 32'd0);
  endtask

  task automatic run_b(input int mode, input int ones, input int first, input logic fv);
    exp_t e;
    int   cyc;
    mode_b  = mode;
    e.ones  = ones;
    e.first = first;
    e.fv    = fv;
    e.sig   = sig_b(mode, 1 << NB);
    @(negedge clk);
    ifb.start = 1'b1;
    qb.push_back(e);
    @(negedge clk);
    ifb.start = 1'b0;
    cyc = 0;
    while (ifb.busy && cyc < SWEEP_B + 16) begin
      cyc++;
      @(negedge clk);
    end
    chk("b_busy_cycles", cyc, SWEEP_B);
    chk("b_done", 32'(ifb.done), 32'd1);
    @(negedge clk);
    chk("b_done_pulse", 32'(ifb.done), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    tbl[0] = '{16'h0000, 0, 0, 1'b0};
    tbl[1] = '{16'hAAAA, 8, 1, 1'b1};
    tbl[2] = '{16'h8000, 1, 15, 1'b1};
    tbl[3] = '{16'hFFFF, 16, 0, 1'b1};
    tbl[4] = '{16'hFF00, 8, 8, 1'b1};
    tbl[5] = '{16'h0010, 1, 4, 1'b1};
    tbl[6] = '{16'h1248, 4, 3, 1'b1};

    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    tt_a = 16'h0000; mode_b = 0;

    // Reset applied before any clock edge: outputs must clear asynchronously.
    #1 rst_n = 1'b0;
    #1;
    chk_reset_a("rst");
    chk("rst_b_busy", 32'(ifb.busy), 32'd0);
    chk("rst_b_ones", 32'(ifb.ones_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_a(i);

    // Start held high: back-to-back sweeps, one DONE and one IDLE cycle apart.
    tt_a    = 16'h0010;
    e.ones  = 1; e.first = 4; e.fv = 1'b1; e.sig = sig_a(16'h0010);
    @(negedge clk);
    ifa.start = 1'b1;
    qa.push_back(e);
    qa.push_back(e);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        chk("held_busy", 32'(ifa.busy), 32'd1);
        chk("held_x", 32'(ifa.x_out), k);
        if (k == 0) begin
          chk("held_clear_ones", 32'(ifa.ones_count), 32'd0);
          chk("held_clear_fv", 32'(ifa.first_one_valid), 32'd0);
          if (pass == 1) ifa.start = 1'b0;
        end
        @(negedge clk);
      end
      chk("held_done", 32'(ifa.done), 32'd1);
      @(negedge clk);
      chk("held_idle_busy", 32'(ifa.busy), 32'd0);
      chk("held_idle_done", 32'(ifa.done), 32'd0);
      chk("held_idle_ones", 32'(ifa.ones_count), 32'd1);
    end

    // Reset pulse mid-sweep at vector 7.
    tt_a = 16'hFFFF;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_x7", 32'(ifa.x_out), 32'd7);
    chk("mid_ones7", 32'(ifa.ones_count), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_a(3);

    // Long sweeps on the 10-input DUT.
    run_b(0, 0, 0, 1'b0);
    run_b(1, 1 << (NB - 1), 1, 1'b1);
    run_b(2, 1 << NB, 0, 1'b1);

    // Abort on cycle 10 of RUN with SETTLE=3: vectors 0 and 1 sampled only.
    mode_b = 2;
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_x", 32'(ifb.x_out), 32'd2);
    ifb.abort = 1'b1;
    @(negedge clk);
    ifb.abort = 1'b0;
    chk("abort_busy", 32'(ifb.busy), 32'd0);
    chk("abort_x", 32'(ifb.x_out), 32'd0);
    chk("abort_done", 32'(ifb.done), 32'd0);
    chk("abort_ones", 32'(ifb.ones_count), 32'd2);
    chk("abort_first", 32'(ifb.first_one), 32'd0);
    chk("abort_fv", 32'(ifb.first_one_valid), 32'd1);
    chk("abort_sig", 32'(ifb.signature), 32'(sig_b(2, 2)));
    repeat (3) @(negedge clk);
    chk("abort_hold_ones", 32'(ifb.ones_count), 32'd2);
    chk("abort_hold_busy", 32'(ifb.busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pla_sweep_driver.md
# pla_sweep_driver

Exhaustive stimulus driver and response compactor for the combinational PLA blocks in this library. On a start request it walks every input vector from 0 to 2^N_IN−1 into a PLA under test, holds each vector for a programmable settle window, and samples the single PLA output. It also accumulates an on-set count, the first on-set minterm and a 16-bit serial signature. It sits beside a PLA instance in the self-test wrapper: its `x_out` feeds the PLA inputs and the PLA output returns on `z_in`.

## Interface

- `N_IN`, 16, PLA input count; legal range 1..20.
- `SETTLE`, 1, extra hold cycles per vector before sampling; legal range 0..15.
- `SIG_POLY`, 16'h1021, feedback polynomial of the signature register.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  cancels a running sweep.
- `z_in`  in  1  PLA output under test.
- `x_out`  out  N_IN  stimulus vector, registered.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  single-cycle pulse when a sweep completes.
- `ones_count`  out  N_IN+1  number of vectors with `z_in`=1.
- `first_one`  out  N_IN  lowest vector with `z_in`=1.
- `first_one_valid`  out  1  `first_one` holds a valid vector.
- `signature`  out  16  serial signature of the response stream.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`=1. On that transition:
  - `x_out`←0, settle counter←0.
  - `ones_count`, `first_one`, `first_one_valid` and `signature` all clear to 0.
- RUN, holding each vector:
  - The settle counter counts 0..SETTLE.
  - When the counter equals SETTLE, `z_in` is sampled on that edge. On the same edge, `x_out` increments and the counter returns to 0.
- Per sample with value z:
  - `ones_count` += z.
  - If z=1 and `first_one_valid`=0: `first_one`←current `x_out`, `first_one_valid`←1.
  - Signature update: `sig` ← {`sig`[14:0],0} XOR (`sig`[15]^z ? SIG_POLY : 0).
- RUN → DONE on the sample taken while `x_out` is all-ones. `x_out` does not wrap into a second pass; it returns to 0 on that edge.
- DONE → IDLE unconditionally after one cycle. `done`=1 only during the DONE cycle.
- `abort`=1 in RUN:
  - Next state is IDLE; `x_out`←0; no `done` pulse.
  - The partially accumulated results remain visible.
  - `abort` has priority over a sample scheduled on the same edge, so that sample is discarded.
- `start` in RUN or DONE is ignored and is not queued.
- `abort` in IDLE or DONE has no effect.
- Results hold their values in IDLE until the next accepted `start`.

## Timing

- Reset values:
  - State IDLE.
  - `x_out`=0, `busy`=0, `done`=0.
  - `ones_count`=0, `first_one`=0, `first_one_valid`=0, `signature`=16'h0000.
- `start` high at edge E: `busy`=1 and `x_out`=0 are visible after E.
- Each vector is held on `x_out` for exactly SETTLE+1 cycles; `busy` stays high for 2^N_IN·(SETTLE+1) cycles.
- The final sample edge sets `busy`=0 and `done`=1. Final result values are valid in that same cycle and remain stable afterwards.
- The earliest next `start` is accepted one cycle after `done`, i.e. in IDLE.
- `rst_n` asserted mid-sweep forces all reset values immediately, without waiting for a clock edge.
- `ones_count` is N_IN+1 bits wide, so the count 2^N_IN does not overflow.

## Test plan

- `z_in` tied 0, N_IN=16, SETTLE=1, pulse `start`:
  - `busy` high for 131072 cycles, then one `done` pulse.
  - `ones_count`=0, `first_one_valid`=0, `signature`=16'h0000.
- `z_in`=`x_out`[0], N_IN=16:
  - `ones_count`=32768, `first_one`=1, `first_one_valid`=1.
  - `signature` equals the bench's bit-serial model of the same stream.
- N_IN=4, SETTLE=0, `z_in`=(`x_out`==4'hF):
  - `busy` high 16 cycles.
  - `ones_count`=1, `first_one`=4'hF.
  - Each `x_out` value is held 1 cycle, checked per cycle.
- N_IN=4, SETTLE=3, `z_in` tied 1, `abort` on cycle 10 of RUN:
  - No `done` pulse; `x_out`=0, `busy`=0 on the next cycle.
  - `ones_count`=2 (vectors 0 and 1 sampled; vector 2's sample is dropped).
- `start` held high continuously, N_IN=4, SETTLE=0:
  - Sweeps run back to back, with one DONE cycle and one IDLE cycle between them.
  - Results clear at each new start; the mid-sweep `start` does not restart the sweep.
- `rst_n` low for 1 cycle at vector 7 of a sweep: all outputs immediately take their reset values; a following `start` completes normally.
